register_file_64: RTL and testbench
===================================

Name: register_file_64

Overview:
- 32 x 64-bit LEGv8 integer register file for the single-cycle datapath.
- Sits directly upstream of the ALUSrc 2:1 64-bit mux. Data2 drives the mux register-operand input; the sign-extended immediate drives the other input.
- Two combinational read ports, one synchronous write port.
- X31 (XZR) is hardwired to zero.

Parameters:
- DATA_WIDTH, 64, width of each register and of the data ports.
- ADDR_WIDTH, 5, register index width (2^ADDR_WIDTH registers).
- ZERO_REG, 31, index that always reads 0 and ignores writes.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST_N  input  1  synchronous active-low reset, sampled on the rising edge of CLK.
- RegWrite  input  1  write enable from the main control unit.
- Read1  input  ADDR_WIDTH  read port 1 index (instruction Rn).
- Read2  input  ADDR_WIDTH  read port 2 index (Rm, or Rt for STUR/CBZ via Reg2Loc mux).
- WriteReg  input  ADDR_WIDTH  write index (Rd/Rt).
- WriteData  input  DATA_WIDTH  write data (MemtoReg mux output).
- Data1  output  DATA_WIDTH  contents of register Read1.
- Data2  output  DATA_WIDTH  contents of register Read2; feeds ALUSrc mux input A.

Behaviour:
- Storage: 31 physical 64-bit registers, indices 0..30. ZERO_REG has no storage.
- Reset:
  - Rising CLK with RST_N=0 clears all 31 registers to 64'h0 in that edge.
  - RegWrite is ignored on a reset edge; reset wins over a simultaneous write.
  - After reset, Data1 and Data2 read 0 for every index.
  - Reset asserted mid-program discards all contents. There is no partial state.
- Write:
  - Rising CLK with RST_N=1, RegWrite=1 and WriteReg != ZERO_REG: reg[WriteReg] <= WriteData.
  - The new value is visible on the read ports after the edge. Write latency is one edge.
  - RegWrite=0 leaves all registers unchanged.
  - A write to ZERO_REG is a no-op.
  - X/Z on WriteData with RegWrite=0 must not corrupt state.
- Read:
  - Purely combinational from the current register contents and the Read address. No clock latency.
  - Data1 = (Read1 == ZERO_REG) ? 0 : reg[Read1]; Data2 is the same with Read2.
  - Read1 == Read2 is legal; both ports return the same value.
- Same-cycle read/write of the same index (default build):
  - The read returns the old value until the edge, then the new value.
  - This keeps the single-cycle critical path free of write-data feed-through.
- Width rules: full DATA_WIDTH stores. No sign extension or truncation inside the block.
- No internal state machine beyond storage. The block must synthesise to flops plus two 32:1 read muxes. No latches.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: a combinational bypass is added to each read port.
  - Condition: RegWrite=1, RST_N=1, WriteReg != ZERO_REG and ReadN == WriteReg.
  - Under that condition DataN = WriteData in the same cycle, before the edge.
  - ReadN == ZERO_REG still returns 0 and is never bypassed.
  - Under reset (RST_N=0) the bypass is disabled and the port returns the stored value.
  - Intended for the later pipelined variant, to cover write-then-read in one cycle.
- Undefined: no bypass; behaviour exactly as in Behaviour.

Test Plan:
1. Reset: write X5=64'hDEAD_BEEF_0000_0001, then one edge with RST_N=0 while RegWrite=1, WriteReg=5, WriteData=64'h1 -> Read1=5 returns 64'h0; a sweep of all 32 indices on both ports returns 0.
2. Write/read: RegWrite=1, WriteReg=9, WriteData=64'hFFFF_FFFF_FFFF_FFFE, one edge -> Read1=9 and Read2=9 both return 64'hFFFF_FFFF_FFFF_FFFE; X8 and X10 remain 0.
3. Zero register: RegWrite=1, WriteReg=31, WriteData=64'h1234, one edge -> Read2=31 returns 0; no other register changes.
4. Write enable off: X3=64'hA5A5 loaded; then RegWrite=0, WriteReg=3, WriteData=64'h0, several edges -> X3 still reads 64'hA5A5.
5. Same-cycle hazard: X7=64'h10; present RegWrite=1, WriteReg=7, WriteData=64'h20 with Read1=7.
   - Default build: Data1=64'h10 before the edge, 64'h20 after.
   - REGFILE_WRITE_BYPASS_EN build: Data1=64'h20 before the edge.
6. Downstream check: drive Data2 into the ALUSrc 2:1 mux with S=0. Write X2=64'h0000_0000_0000_0040 and set Read2=2 -> mux output is 64'h40. With S=1 the mux output equals the immediate input regardless of X2.

Source files
------------

// File: rtl/register_file_64.sv
// ---------------------------------------------------------------------------
// register_file_64
//   32 x 64-bit LEGv8 integer register file for the single-cycle datapath.
//   Two combinational read ports and one synchronous write port. Index
//   ZERO_REG (X31 / XZR) has no storage: it always reads zero and writes to
//   it are dropped.
//
//   Data2 feeds the register-operand input of the downstream ALUSrc 2:1 mux.
//
// Parameters
//   DATA_WIDTH : register / data-port width (default 64)
//   ADDR_WIDTH : register index width, 2**ADDR_WIDTH architectural indices
//   ZERO_REG   : index hardwired to zero (default 31)
//
// Ports
//   CLK       in   clock, all state changes on the rising edge
//   RST_N     in   synchronous active-low reset, clears every register
//   RegWrite  in   write enable from the main control unit
//   Read1     in   read port 1 index (Rn)
//   Read2     in   read port 2 index (Rm, or Rt via Reg2Loc)
//   WriteReg  in   write index (Rd/Rt)
//   WriteData in   write data (MemtoReg mux output)
//   Data1     out  contents of register Read1
//   Data2     out  contents of register Read2
//
// Build option
//   REGFILE_WRITE_BYPASS_EN : when defined, each read port forwards
//   WriteData combinationally when it reads the register being written in
//   the same cycle (outside reset, never for ZERO_REG). When undefined, a
//   read of the register being written returns the old value until the edge.
// ---------------------------------------------------------------------------
module register_file_64 #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 31
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  RegWrite,
   input  logic [ADDR_WIDTH-1:0] Read1,
   input  logic [ADDR_WIDTH-1:0] Read2,
   input  logic [ADDR_WIDTH-1:0] WriteReg,
   input  logic [DATA_WIDTH-1:0] WriteData,
   output logic [DATA_WIDTH-1:0] Data1,
   output logic [DATA_WIDTH-1:0] Data2
);

   localparam int NREGS = 2 ** ADDR_WIDTH;
   // The zero register owns no storage, so one fewer physical register.
   localparam int NPHYS = NREGS - 1;
   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);
   localparam logic [ADDR_WIDTH-1:0] ONE_IDX  = ADDR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem [NPHYS];

   logic                  wr_hit;
   logic [ADDR_WIDTH-1:0] wr_phys;
   logic [ADDR_WIDTH-1:0] rd1_phys;
   logic [ADDR_WIDTH-1:0] rd2_phys;

   // Architectural index -> physical slot. Indices above ZERO_REG slide
   // down by one to close the hole left by the zero register.
   function automatic logic [ADDR_WIDTH-1:0] phys_idx(
      input logic [ADDR_WIDTH-1:0] idx
   );
      logic [ADDR_WIDTH-1:0] p;
      p = idx;
      if (idx > ZERO_IDX) begin
         p = idx - ONE_IDX;
      end
      return p;
   endfunction

   assign wr_hit   = RegWrite && (WriteReg != ZERO_IDX);
   assign wr_phys  = phys_idx(WriteReg);
   assign rd1_phys = phys_idx(Read1);
   assign rd2_phys = phys_idx(Read2);

   // ---- storage: reset clears everything and wins over a write ----
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int i = 0; i < NPHYS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_hit) begin
         mem[wr_phys] <= WriteData;
      end
   end

   // ---- read port 1 ----
   always_comb begin
      Data1 = '0;
      if (Read1 != ZERO_IDX) begin
         Data1 = mem[rd1_phys];
`ifdef REGFILE_WRITE_BYPASS_EN
         // Forward the in-flight write; wr_hit already excludes ZERO_REG.
         if (RST_N && wr_hit && (Read1 == WriteReg)) begin
            Data1 = WriteData;
         end
`endif
      end
   end

   // ---- read port 2 ----
   always_comb begin
      Data2 = '0;
      if (Read2 != ZERO_IDX) begin
         Data2 = mem[rd2_phys];
`ifdef REGFILE_WRITE_BYPASS_EN
         if (RST_N && wr_hit && (Read2 == WriteReg)) begin
            Data2 = WriteData;
         end
`endif
      end
   end

endmodule

// File: tb/tb_register_file_64.sv
// ---------------------------------------------------------------------------
// tb_register_file_64
//   Directed bench for register_file_64 with hand-computed expectations.
//   Includes a behavioural ALUSrc 2:1 mux on Data2 for the downstream check.
// ---------------------------------------------------------------------------
module tb_register_file_64;

   logic        CLK;
   logic        RST_N;
   logic        RegWrite;
   logic [4:0]  Read1;
   logic [4:0]  Read2;
   logic [4:0]  WriteReg;
   logic [63:0] WriteData;
   logic [63:0] Data1;
   logic [63:0] Data2;

   // downstream ALUSrc mux: S=0 selects Data2, S=1 selects the immediate
   logic        alusrc;
   logic [63:0] imm;
   logic [63:0] alu_b;
   assign alu_b = alusrc ? imm : Data2;

   int n_cmp;
   int n_bad;

   register_file_64 #(
      .DATA_WIDTH(64),
      .ADDR_WIDTH(5),
      .ZERO_REG  (31)
   ) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .RegWrite (RegWrite),
      .Read1    (Read1),
      .Read2    (Read2),
      .WriteReg (WriteReg),
      .WriteData(WriteData),
      .Data1    (Data1),
      .Data2    (Data2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // advance one rising edge, then settle away from it
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [4:0] idx, input logic [63:0] val);
      RegWrite  = 1'b1;
      WriteReg  = idx;
      WriteData = val;
      tick();
      RegWrite  = 1'b0;
   endtask

   function automatic logic [63:0] pat(input int i);
      return 64'hC0DE_0000_0000_0000 | (64'(i) << 16) | 64'(i * 3 + 1);
   endfunction

   logic [63:0] exp_bypass;

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      RST_N     = 1'b0;
      RegWrite  = 1'b0;
      Read1     = '0;
      Read2     = '0;
      WriteReg  = '0;
      WriteData = '0;
      alusrc    = 1'b0;
      imm       = '0;
      tick();
      tick();

      // ---- reset state: every index reads zero on both ports ----
      for (int i = 0; i < 32; i++) begin
         Read1 = 5'(i);
         Read2 = 5'(31 - i);
         #1;
         chk($sformatf("rst0_r1_x%0d", i), Data1, 64'h0);
         chk($sformatf("rst0_r2_x%0d", 31 - i), Data2, 64'h0);
      end

      // ---- fill every register, verify readback ----
      RST_N = 1'b1;
      for (int i = 0; i < 31; i++) wr(5'(i), pat(i));
      wr(5'd5, 64'hDEAD_BEEF_0000_0001);
      for (int i = 0; i < 31; i++) begin
         Read1 = 5'(i);
         Read2 = 5'(i);
         #1;
         chk($sformatf("fill_r1_x%0d", i), Data1,
             (i == 5) ? 64'hDEAD_BEEF_0000_0001 : pat(i));
         chk($sformatf("fill_r2_x%0d", i), Data2,
             (i == 5) ? 64'hDEAD_BEEF_0000_0001 : pat(i));
      end

      // ---- reset edge with a simultaneous write: reset wins ----
      Read1     = 5'd5;
      RST_N     = 1'b0;
      RegWrite  = 1'b1;
      WriteReg  = 5'd5;
      WriteData = 64'h1;
      #1;
      chk("rst_nobypass_x5", Data1, 64'hDEAD_BEEF_0000_0001);
      tick();
      RST_N    = 1'b1;
      RegWrite = 1'b0;
      #1;
      chk("rst_x5", Data1, 64'h0);
      for (int i = 0; i < 32; i++) begin
         Read1 = 5'(i);
         Read2 = 5'(i);
         #1;
         chk($sformatf("rst1_r1_x%0d", i), Data1, 64'h0);
         chk($sformatf("rst1_r2_x%0d", i), Data2, 64'h0);
      end

      // ---- write/read X9 ----
      wr(5'd9, 64'hFFFF_FFFF_FFFF_FFFE);
      Read1 = 5'd9; Read2 = 5'd9; #1;
      chk("wr_x9_r1", Data1, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("wr_x9_r2", Data2, 64'hFFFF_FFFF_FFFF_FFFE);
      Read1 = 5'd8; Read2 = 5'd10; #1;
      chk("wr_x8_zero", Data1, 64'h0);
      chk("wr_x10_zero", Data2, 64'h0);

      // ---- zero register ignores writes ----
      wr(5'd31, 64'h1234);
      Read1 = 5'd31; Read2 = 5'd31; #1;
      chk("xzr_r1", Data1, 64'h0);
      chk("xzr_r2", Data2, 64'h0);
      for (int i = 0; i < 31; i++) begin
         Read1 = 5'(i);
         #1;
         chk($sformatf("xzr_other_x%0d", i), Data1,
             (i == 9) ? 64'hFFFF_FFFF_FFFF_FFFE : 64'h0);
      end

      // ---- write enable off ----
      wr(5'd3, 64'hA5A5);
      RegWrite  = 1'b0;
      WriteReg  = 5'd3;
      WriteData = 64'h0;
      Read1     = 5'd3;
      #1;
      chk("we0_pre_x3", Data1, 64'hA5A5);
      tick(); tick(); tick();
      chk("we0_post_x3", Data1, 64'hA5A5);

      // ---- same-cycle read/write of X7 ----
      wr(5'd7, 64'h10);
`ifdef REGFILE_WRITE_BYPASS_EN
      exp_bypass = 64'h20;
`else
      exp_bypass = 64'h10;
`endif
      Read1     = 5'd7;
      Read2     = 5'd6;
      RegWrite  = 1'b1;
      WriteReg  = 5'd7;
      WriteData = 64'h20;
      #1;
      chk("haz_pre_x7", Data1, exp_bypass);
      chk("haz_other_x6", Data2, 64'h0);
      tick();
      chk("haz_post_x7", Data1, 64'h20);
      // a write aimed at XZR is never forwarded
      WriteReg  = 5'd31;
      WriteData = 64'hFF;
      Read2     = 5'd31;
      #1;
      chk("haz_xzr", Data2, 64'h0);
      RegWrite = 1'b0;

      // ---- downstream ALUSrc mux ----
      wr(5'd2, 64'h0000_0000_0000_0040);
      Read2  = 5'd2;
      alusrc = 1'b0;
      imm    = 64'hFFFF_FFFF_FFFF_FFF0;
      #1;
      chk("mux_s0", alu_b, 64'h40);
      alusrc = 1'b1;
      #1;
      chk("mux_s1", alu_b, 64'hFFFF_FFFF_FFFF_FFF0);
      wr(5'd2, 64'h99);
      chk("mux_s1_x2chg", alu_b, 64'hFFFF_FFFF_FFFF_FFF0);
      alusrc = 1'b0;
      #1;
      chk("mux_s0_x2chg", alu_b, 64'h99);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
